// File: rtl/ervp_memory_cell_nr1wc_if.sv
// Bus bundle for ervp_memory_cell_nr1wc: one write port, NUM_RPORT read ports, clear/busy.
interface ervp_memory_cell_nr1wc_if #(
  parameter int WIDTH     = 32,
  parameter int BW_INDEX  = 4,
  parameter int NUM_RPORT = 2,
  parameter int BW_SELECT = 1
);
  logic [BW_INDEX-1:0]           windex;
  logic                          wenable;
  logic [BW_SELECT-1:0]          wpermit;
  logic [WIDTH-1:0]              wdata;
  logic [NUM_RPORT*BW_INDEX-1:0] rindex;
  logic [NUM_RPORT-1:0]          renable;
  logic [NUM_RPORT*WIDTH-1:0]    rdata_synch;
  logic [NUM_RPORT-1:0]          rvalid;
  logic                          clear;
  logic                          busy;

  modport master (
    output windex, wenable, wpermit, wdata, rindex, renable, clear,
    input  rdata_synch, rvalid, busy
  );
  modport slave (
    input  windex, wenable, wpermit, wdata, rindex, renable, clear,
    output rdata_synch, rvalid, busy
  );
endinterface

// File: rtl/ervp_memory_cell_nr1wc.sv
// Multi-read-port synchronous memory cell with write-first forwarding and a zeroing sweep.
// Define ERVP_MEMCELL_CLEAR_ON_RESET_EN to start the sweep automatically when reset releases.
module ervp_memory_cell_nr1wc_rport #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ren,
  input  logic             in_range,
  input  logic             hit,
  input  logic [WIDTH-1:0] wbits,
  input  logic [WIDTH-1:0] wval,
  input  logic [WIDTH-1:0] old,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);
  logic [WIDTH-1:0]                    fwd;
  logic [READ_LATENCY:1]               vld_pipe;
  logic [READ_LATENCY:1][WIDTH-1:0]    data_pipe;

  always_comb begin
    fwd = '0;
    if (in_range) fwd = hit ? ((old & ~wbits) | (wval & wbits)) : old;
  end

  // data stages only advance with their valid bit, so outputs hold between results
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= ren;
      if (ren) data_pipe[1] <= fwd;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rdata  = data_pipe[READ_LATENCY];
  assign rvalid = vld_pipe[READ_LATENCY];
endmodule

module ervp_memory_cell_nr1wc #(
  parameter int DEPTH              = 16,
  parameter int WIDTH              = 32,
  parameter int BW_INDEX           = 4,
  parameter int NUM_RPORT          = 2,
  parameter int USE_SUBWORD_ENABLE = 0,
  parameter int BW_SUBWORD         = 8,
  parameter int READ_LATENCY       = 1
) (
  input logic                     clk,
  input logic                     rst,
  ervp_memory_cell_nr1wc_if.slave bus
);
  localparam int BW_SELECT = (USE_SUBWORD_ENABLE != 0) ? (WIDTH + BW_SUBWORD - 1) / BW_SUBWORD : 1;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BW_INDEX:0]   DEPTH_W  = (BW_INDEX+1)'(DEPTH);
  localparam logic [BW_INDEX-1:0] LAST_IDX = BW_INDEX'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t              state, state_nxt;
  logic [BW_INDEX-1:0] cnt, cnt_nxt;
  logic                pend_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef ERVP_MEMCELL_CLEAR_ON_RESET_EN
      pend_clr <= 1'b1;
`else
      pend_clr <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == CLEAR) pend_clr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (bus.clear || pend_clr) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        cnt_nxt = cnt + BW_INDEX'(1);
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Effective write: the sweep owns the port while busy, external writes are dropped
  logic                 sweep, ext_we, we;
  logic [AW-1:0]        widx;
  logic [WIDTH-1:0]     ext_bits, wbits, wval;
  logic [BW_SELECT-1:0] permit;
  logic                 unused_permit;

  assign permit        = bus.wpermit;
  assign unused_permit = ^permit;

  for (genvar b = 0; b < WIDTH; b++) begin : g_wbits
    if (USE_SUBWORD_ENABLE != 0) begin : g_sub
      assign ext_bits[b] = permit[b / BW_SUBWORD];
    end else begin : g_full
      assign ext_bits[b] = 1'b1;
    end
  end

  assign sweep    = (state == CLEAR);
  assign bus.busy = sweep;
  assign ext_we   = bus.wenable && ({1'b0, bus.windex} < DEPTH_W);
  assign we       = sweep || ext_we;
  assign widx     = sweep ? cnt[AW-1:0] : bus.windex[AW-1:0];
  assign wbits    = sweep ? '1 : ext_bits;
  assign wval     = sweep ? '0 : bus.wdata;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= (mem[widx] & ~wbits) | (wval & wbits);
  end

  logic [NUM_RPORT-1:0][WIDTH-1:0] rdata;
  logic [NUM_RPORT-1:0]            rvalid;

  for (genvar p = 0; p < NUM_RPORT; p++) begin : g_rport
    logic [BW_INDEX-1:0] ridx;
    logic                in_range, hit;
    assign ridx     = bus.rindex[p*BW_INDEX +: BW_INDEX];
    assign in_range = ({1'b0, ridx} < DEPTH_W);
    assign hit      = we && (ridx[AW-1:0] == widx);

    ervp_memory_cell_nr1wc_rport #(
      .WIDTH        (WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_rport (
      .clk      (clk),
      .rst      (rst),
      .ren      (bus.renable[p]),
      .in_range (in_range),
      .hit      (hit),
      .wbits    (wbits),
      .wval     (wval),
      .old      (mem[ridx[AW-1:0]]),
      .rdata    (rdata[p]),
      .rvalid   (rvalid[p])
    );
  end

  assign bus.rdata_synch = rdata;
  assign bus.rvalid      = rvalid;
endmodule

// File: doc/ervp_memory_cell_nr1wc.md
Name: ervp_memory_cell_nr1wc

Overview:
- Multi-read-port successor of the single-read synchronous memory cell: one write port, NUM_RPORT independent synchronous read ports.
- Per-subword write-first forwarding on every read port. Selectable read latency of 1 or 2 cycles.
- Built-in clear sequencer that zeroes the array one entry per cycle.
- Used as register-file or buffer storage inside accelerator datapaths needing several simultaneous reads.

Parameters:
- DEPTH, 16, number of entries.
- WIDTH, 32, bits per entry.
- BW_INDEX, 4, index width; must be >= ceil(log2(DEPTH)).
- NUM_RPORT, 2, number of read ports; range 1..8.
- USE_SUBWORD_ENABLE, 0, 1 = wpermit masks subwords; 0 = whole-word write.
- BW_SUBWORD, 8, subword width in bits.
- READ_LATENCY, 1, cycles from sampled renable to data; only 1 or 2 legal.
- BW_SELECT, derived, ceil(WIDTH/BW_SUBWORD) if USE_SUBWORD_ENABLE else 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- windex  in  BW_INDEX  write index.
- wenable  in  1  write request.
- wpermit  in  BW_SELECT  per-subword write mask; ignored when USE_SUBWORD_ENABLE=0.
- wdata  in  WIDTH  write data.
- rindex  in  NUM_RPORT*BW_INDEX  read indices; port p at slice [p*BW_INDEX +: BW_INDEX].
- renable  in  NUM_RPORT  per-port read request.
- rdata_synch  out  NUM_RPORT*WIDTH  read data; port p at slice [p*WIDTH +: WIDTH].
- rvalid  out  NUM_RPORT  one-cycle pulse, high when the port's rdata_synch carries new data.
- clear  in  1  single-cycle request to start the zeroing sweep.
- busy  out  1  high while the sweep runs.

Behaviour:
Reset (rst high at an edge):
- rdata_synch=0, rvalid=0, sweep FSM in IDLE, busy=0, pipeline stages cleared.
- Array contents are not reset.
- rst during a sweep aborts it; entries not yet swept keep their old values.

Write:
- At an edge with wenable=1, busy=0 and windex<DEPTH, subword s of mem[windex] takes wdata when wpermit[s]=1.
- With USE_SUBWORD_ENABLE=0, the whole word is written.
- windex>=DEPTH: write dropped.
- wenable while busy=1: dropped silently.

Read port p:
- renable[p] sampled at edge k gives rdata_synch[p] and rvalid[p]=1 after edge k+READ_LATENCY-1, visible for one cycle.
- Between results, rdata_synch[p] holds its last value and rvalid[p]=0.
- Returned data is the contents of mem[rindex_p] as of edge k, with forwarding applied:
  - If the effective write at edge k (external or sweep) targets the same index, each subword the write enables returns the new data; the other subwords return the old data.
  - Forwarding is resolved per port, so all ports reading the written index see the new data.
- rindex_p>=DEPTH returns all zeros.
- READ_LATENCY=2: stage 1 captures data at edge k; stage 2 registers it at edge k+1. Back-to-back reads every cycle are fully pipelined.
- A write at edge k+1 does not alter a read sampled at edge k.
- Ports are independent; any combination may read the same or different indices in the same cycle.

Sweep FSM (states IDLE, CLEAR):
- IDLE -> CLEAR when clear=1 at an edge; the counter loads 0.
- In CLEAR, each edge writes zero to mem[counter], then counter+1.
- CLEAR -> IDLE at the edge that writes index DEPTH-1.
- busy=1 exactly while in CLEAR: DEPTH cycles, starting the cycle after clear is sampled.
- clear while busy: ignored.
- Reads are allowed during the sweep; sweep writes forward like external writes (full-word, zero data).

Width rules:
- Index comparisons use the low ceil(log2(DEPTH)) bits only after the out-of-range check against DEPTH.
- The last subword may be narrower than BW_SUBWORD when WIDTH is not a multiple of it; its wpermit bit covers the remaining bits.

Optional Feature:
ERVP_MEMCELL_CLEAR_ON_RESET_EN
- Defined: the first edge with rst=0 after reset enters CLEAR automatically. busy=1 for DEPTH cycles and the array reads zero afterwards. rst mid-sweep restarts the sweep from index 0 once rst falls.
- Undefined: the FSM stays in IDLE after reset and array contents are undefined until written.

Test Plan:
- Default params, READ_LATENCY=1: write 0xA5A5A5A5 to idx 3. Next cycle port0 and port1 both read idx 3 -> both rdata=0xA5A5A5A5 with rvalid=1 one cycle later.
- USE_SUBWORD_ENABLE=1: mem[5]=0x11223344. Same edge: write 0xAABBCCDD with wpermit=4'b0101 to idx 5, and port0 reads idx 5 -> 0x11BB33DD. Port1 reads idx 5 the next cycle -> same value.
- READ_LATENCY=2, reads issued every cycle on idx 0,1,2 (mem = 10,20,30) -> rvalid on 3 consecutive cycles starting 2 edges later, data 10,20,30. Writing 99 to idx 0 one edge after its read -> port still returns 10.
- DEPTH=16: pulse clear -> busy high exactly 16 cycles. wenable during busy is dropped. A port0 read of idx 7 issued during the cycle idx 7 is being cleared -> 0. Afterwards all 16 entries read 0.
- rindex=20 with DEPTH=16 -> rdata=0 with rvalid=1. wenable with windex=17 -> no entry changes.
- Assert rst at sweep cycle 5 -> busy=0, rvalid=0, rdata=0 next cycle. With ERVP_MEMCELL_CLEAR_ON_RESET_EN -> sweep restarts at idx 0 after rst falls and busy stays high 16 cycles.
